dragster_spi_arbiter: RTL and testbench
=======================================

# dragster_spi_arbiter

Shares one SPI master engine between two configuration requesters. Each requester owns one chip select on the two-slave Dragster sensor SPI bus. The block arbitrates round-robin and runs one fixed-length 16-bit mode-0 frame per grant. It returns the captured MISO word with a one-cycle acknowledge, and sits between the configuration sequencers and the sensor pins.

## Interface
- CLK_DIV, default 4: SCLK half-period in clk cycles. Legal range ≥1; 0 is illegal.
- FRAME_WIDTH, default 16: bits per SPI frame, MSB first.
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- req0, req1  in  1 each  transaction request from requester 0 or 1.
- tx_data0, tx_data1  in  FRAME_WIDTH  frame to send; must stay stable while the matching req is high.
- ack0, ack1  out  1 each  one-cycle pulse marking the end of that requester's frame.
- rx_data  out  FRAME_WIDTH  word captured from MISO; valid from the ack cycle until the next ack.
- busy  out  1  high whenever the state is not IDLE.
- miso  in  1  serial data from the slave.
- mosi  out  1  serial data to the slave.
- sclk  out  1  SPI clock; idles low.
- ss_n  out  2  active-low selects; ss_n[i] belongs to requester i.

## Operation
- All outputs are registered.
- Reset values: ss_n=2'b11, sclk=0, mosi=0, ack0=ack1=0, rx_data=0, busy=0, state=IDLE, last_grant=1. Because last_grant resets to 1, requester 0 wins the first contention.
- Arbitration happens only in IDLE:
  - If only one req is high, that requester is granted.
  - If both are high, the requester other than last_grant is granted.
  - last_grant updates at grant time.
  - Requests are ignored in every state other than IDLE.
- SPI mode 0:
  - mosi is valid before each rising sclk edge and changes only while sclk is low.
  - miso is sampled into the shift register on the clk edge where sclk goes 0→1.
- States, each timed by a counter of CLK_DIV cycles:
  - IDLE: on grant g, load tx_data_g into the shift register, drive ss_n[g]=0, drive mosi=MSB, go to SETUP.
  - SETUP: after CLK_DIV cycles, set sclk=1, sample miso, go to HIGH.
  - HIGH: after CLK_DIV cycles, set sclk=0. If this was the last bit, go to HOLD. Otherwise drive the next mosi bit and go to LOW.
  - LOW: after CLK_DIV cycles, set sclk=1, sample miso, go to HIGH.
  - HOLD: after CLK_DIV cycles, set ss_n=2'b11, pulse ack_g for one cycle, load rx_data, set mosi=0, go to GAP.
  - GAP: after CLK_DIV cycles, go to IDLE.
- Requester protocol:
  - The requester drops req in the cycle after it sees ack.
  - If req is still high when the arbiter reaches IDLE, that is a new request.
- Reset mid-frame: all outputs return to reset values on the next clk edge. No ack is issued for the aborted frame, and rx_data returns to 0.
- A request toggling while another requester's frame is in progress has no effect on that frame.

## Timing
- Request latency: req is sampled in IDLE at edge E0; ss_n[g] goes low in the cycle after E0.
- ss_n low duration: CLK_DIV×(2×FRAME_WIDTH+1) cycles, which is 132 for the defaults.
- SCLK:
  - Period 2×CLK_DIV clk cycles.
  - Exactly FRAME_WIDTH rising edges per frame.
  - First rising edge CLK_DIV cycles after ss_n falls.
  - Last falling edge CLK_DIV cycles before ss_n rises.
- ack: asserted in the same cycle ss_n returns to 2'b11; exactly one cycle wide.
- Minimum ss_n-high gap between back-to-back frames: CLK_DIV+1 cycles (GAP plus one IDLE cycle).
- Both requesters held high: grants alternate 0,1,0,1… and neither starves.
- At most one ss_n bit is ever low.

## Test plan
- Reset:
  - Stimulus: hold reset 3 cycles with random req.
  - Required: ss_n=11, sclk=0, mosi=0, ack0=ack1=0, rx_data=0, busy=0.
- Loopback frame:
  - Stimulus: miso=mosi, req0 with tx_data0=16'hA55A, defaults.
  - Required: ss_n=10 for 132 cycles; 16 sclk rising edges; mosi bit sequence 1010010101011010; single ack0 pulse; rx_data=16'hA55A.
- MISO capture:
  - Stimulus: miso tied 1, req1 with tx_data1=16'h0000.
  - Required: ss_n=01; mosi stays 0; ack1 pulses; rx_data=16'hFFFF; ack0 never asserts.
- Contention:
  - Stimulus: after reset, req0 and req1 both held high for four frames.
  - Required: ss_n sequence 10,01,10,01; ss_n=11 for 5 cycles between frames; acks alternate ack0, ack1.
- Reset mid-frame:
  - Stimulus: assert reset 1 cycle after the 8th sclk rising edge of a req0 frame, then issue req1 with tx_data1=16'h1234 and loopback.
  - Required: the aborted frame gets no ack0 and rx_data=0; the req1 frame then completes with rx_data=16'h1234.
- CLK_DIV=1:
  - Stimulus: instantiate with CLK_DIV=1 and send a loopback frame of 16'h8001.
  - Required: ss_n low 33 cycles; sclk period 2 cycles; rx_data=16'h8001.

Source files
------------

// File: rtl/dragster_spi_arbiter.sv
// Round-robin arbiter that shares one SPI mode-0 master between two requesters.
// Each grant runs one fixed-length frame and returns the MISO word with a one-cycle ack.
module dragster_spi_arbiter #(
  parameter int CLK_DIV     = 4,
  parameter int FRAME_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req0,
  input  logic                   req1,
  input  logic [FRAME_WIDTH-1:0] tx_data0,
  input  logic [FRAME_WIDTH-1:0] tx_data1,
  output logic                   ack0,
  output logic                   ack1,
  output logic [FRAME_WIDTH-1:0] rx_data,
  output logic                   busy,
  input  logic                   miso,
  output logic                   mosi,
  output logic                   sclk,
  output logic [1:0]             ss_n
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(FRAME_WIDTH + 1);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, GAP} state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [BW-1:0]          bits;
  logic [FRAME_WIDTH-1:0] shreg;
  logic                   grant;
  logic                   last_grant;
  logic                   phase_done;
  logic                   pick;

  assign phase_done = (cnt == CW'(CLK_DIV - 1));
  // On contention the requester that did not win last time goes next.
  assign pick = (req0 && req1) ? ~last_grant : req1;

  // One register shifts tx out of the MSB and miso in at the LSB, so after
  // the last rising edge it holds the received word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      bits       <= '0;
      shreg      <= '0;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rx_data    <= '0;
      busy       <= 1'b0;
      mosi       <= 1'b0;
      sclk       <= 1'b0;
      ss_n       <= 2'b11;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      if (state != IDLE) cnt <= phase_done ? '0 : cnt + 1'b1;
      case (state)
        IDLE: if (req0 || req1) begin
          grant      <= pick;
          last_grant <= pick;
          shreg      <= pick ? tx_data1 : tx_data0;
          mosi       <= pick ? tx_data1[FRAME_WIDTH-1] : tx_data0[FRAME_WIDTH-1];
          ss_n       <= pick ? 2'b01 : 2'b10;
          busy       <= 1'b1;
          bits       <= '0;
          cnt        <= '0;
          state      <= SETUP;
        end
        SETUP, LOW: if (phase_done) begin
          sclk  <= 1'b1;
          shreg <= {shreg[FRAME_WIDTH-2:0], miso};
          bits  <= bits + 1'b1;
          state <= HIGH;
        end
        HIGH: if (phase_done) begin
          sclk <= 1'b0;
          if (bits == BW'(FRAME_WIDTH)) begin
            state <= HOLD;
          end else begin
            mosi  <= shreg[FRAME_WIDTH-1];
            state <= LOW;
          end
        end
        HOLD: if (phase_done) begin
          ss_n    <= 2'b11;
          ack0    <= ~grant;
          ack1    <= grant;
          rx_data <= shreg;
          mosi    <= 1'b0;
          state   <= GAP;
        end
        GAP: if (phase_done) begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dragster_spi_arbiter.sv
// Directed bench for dragster_spi_arbiter: default instance plus a CLK_DIV=1 instance.
module tb_dragster_spi_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, req0, req1, ack0, ack1, busy, miso, mosi, sclk;
  logic [15:0] tx0, tx1, rx;
  logic [1:0]  ss_n;
  logic        loop, miso_val;
  assign miso = loop ? mosi : miso_val;

  dragster_spi_arbiter dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1),
    .tx_data0(tx0), .tx_data1(tx1), .ack0(ack0), .ack1(ack1),
    .rx_data(rx), .busy(busy), .miso(miso), .mosi(mosi), .sclk(sclk), .ss_n(ss_n)
  );

  logic        reqb0, reqb1, ackb0, ackb1, busyb, misob, mosib, sclkb;
  logic [15:0] txb0, txb1, rxb;
  logic [1:0]  ssb;
  assign misob = mosib;

  dragster_spi_arbiter #(.CLK_DIV(1), .FRAME_WIDTH(16)) dut1 (
    .clk(clk), .reset(reset), .req0(reqb0), .req1(reqb1),
    .tx_data0(txb0), .tx_data1(txb1), .ack0(ackb0), .ack1(ackb1),
    .rx_data(rxb), .busy(busyb), .miso(misob), .mosi(mosib), .sclk(sclkb), .ss_n(ssb)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bus monitor for the default instance, sampled on the falling clk edge.
  logic        mon_clr;
  int          low_cnt, rises, ack0_cnt, ack1_cnt, mosi_ones, both_low, starts, hi_run;
  int          gap_min, gap_max;
  logic [15:0] mosi_bits;
  logic [1:0]  last_low, ss_q;
  logic [7:0]  seq;
  logic        sclk_q;

  always @(negedge clk) begin
    if (mon_clr) begin
      low_cnt <= 0; rises <= 0; ack0_cnt <= 0; ack1_cnt <= 0; mosi_ones <= 0;
      both_low <= 0; starts <= 0; hi_run <= 0; gap_min <= 999; gap_max <= 0;
      mosi_bits <= '0; last_low <= 2'b11; seq <= '0; sclk_q <= sclk; ss_q <= ss_n;
    end else begin
      if (ss_n != 2'b11 && ss_q == 2'b11) begin
        if (starts > 0) begin
          if (hi_run < gap_min) gap_min <= hi_run;
          if (hi_run > gap_max) gap_max <= hi_run;
        end
        starts <= starts + 1;
        seq    <= {seq[5:0], ss_n};
      end
      if (ss_n == 2'b11) hi_run <= hi_run + 1;
      else begin
        hi_run   <= 0;
        low_cnt  <= low_cnt + 1;
        last_low <= ss_n;
      end
      if (ss_n == 2'b00) both_low <= both_low + 1;
      if (sclk && !sclk_q) begin
        rises     <= rises + 1;
        mosi_bits <= {mosi_bits[14:0], mosi};
      end
      if (mosi) mosi_ones <= mosi_ones + 1;
      if (ack0) ack0_cnt <= ack0_cnt + 1;
      if (ack1) ack1_cnt <= ack1_cnt + 1;
      sclk_q <= sclk;
      ss_q   <= ss_n;
    end
  end

  // Monitor for the CLK_DIV=1 instance.
  int         lowb = 0, risesb = 0, perb = 0, lastrise = 0, cyc = 0;
  logic       sclkb_q = 1'b0;
  logic [1:0] lastlowb = 2'b11;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (ssb != 2'b11) begin
      lowb     <= lowb + 1;
      lastlowb <= ssb;
    end
    if (sclkb && !sclkb_q) begin
      risesb <= risesb + 1;
      if (risesb > 0) perb <= cyc - lastrise;
      lastrise <= cyc;
    end
    sclkb_q <= sclkb;
  end

  logic got0, got1;

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clk); #1;
    mon_clr = 1'b0;
  endtask

  task automatic wait_ack(input string tag, input int budget);
    got0 = 1'b0;
    got1 = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (ack0 || ack1) begin
        got0 = ack0;
        got1 = ack1;
        break;
      end
    end
    chk(tag, {31'd0, got0 | got1}, 32'd1);
  endtask

  logic [3:0] order;

  initial begin
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; tx0 = '0; tx1 = '0;
    loop = 1'b0; miso_val = 1'b0; mon_clr = 1'b1;
    reqb0 = 1'b0; reqb1 = 1'b0; txb0 = '0; txb1 = '0;

    // Reset with random requests
    repeat (3) begin
      @(posedge clk); #1;
      req0 = 1'($urandom_range(0, 1));
      req1 = 1'($urandom_range(0, 1));
    end
    @(negedge clk); #1;
    chk("rst_ss_n", ss_n, 2'b11);
    chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_ack0", ack0, 0);
    chk("rst_ack1", ack1, 0);
    chk("rst_rx", rx, 0);
    chk("rst_busy", busy, 0);
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;

    // Loopback frame on requester 0
    tx0 = 16'hA55A; loop = 1'b1;
    clear_mon();
    req0 = 1'b1;
    wait_ack("lb_ack_seen", 400);
    req0 = 1'b0;
    chk("lb_ack0", got0, 1);
    chk("lb_rx", rx, 16'hA55A);
    repeat (3) @(negedge clk); #1;
    chk("lb_low_cycles", low_cnt, 132);
    chk("lb_rises", rises, 16);
    chk("lb_mosi_bits", mosi_bits, 16'hA55A);
    chk("lb_ack0_cnt", ack0_cnt, 1);
    chk("lb_ack1_cnt", ack1_cnt, 0);
    chk("lb_ss_n", last_low, 2'b10);

    // MISO capture on requester 1
    loop = 1'b0; miso_val = 1'b1; tx1 = 16'h0000;
    clear_mon();
    req1 = 1'b1;
    wait_ack("cap_ack_seen", 400);
    req1 = 1'b0;
    chk("cap_ack1", got1, 1);
    chk("cap_rx", rx, 16'hFFFF);
    repeat (3) @(negedge clk); #1;
    chk("cap_ss_n", last_low, 2'b01);
    chk("cap_mosi_ones", mosi_ones, 0);
    chk("cap_ack0_cnt", ack0_cnt, 0);
    chk("cap_ack1_cnt", ack1_cnt, 1);

    // Contention: both held for four frames after reset
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    tx0 = 16'h1111; tx1 = 16'h2222; loop = 1'b1;
    clear_mon();
    req0 = 1'b1; req1 = 1'b1;
    order = '0;
    for (int k = 0; k < 4; k++) begin
      wait_ack("ct_ack_seen", 400);
      order = {order[2:0], got1};
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) @(negedge clk); #1;
    chk("ct_ss_seq", seq, 8'b10_01_10_01);
    chk("ct_gap_min", gap_min, 5);
    chk("ct_gap_max", gap_max, 5);
    chk("ct_ack_order", order, 4'b0101);
    chk("ct_both_low", both_low, 0);
    chk("ct_ack0_cnt", ack0_cnt, 2);
    chk("ct_ack1_cnt", ack1_cnt, 2);
    chk("ct_rx", rx, 16'h2222);

    // Reset in the middle of a requester 0 frame
    tx0 = 16'hFFFF; loop = 1'b1;
    clear_mon();
    req0 = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (rises >= 8) break;
    end
    chk("mr_rises_before", rises, 8);
    req0 = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk); #1;
    chk("mr_ss_n", ss_n, 2'b11);
    chk("mr_sclk", sclk, 0);
    chk("mr_rx", rx, 0);
    chk("mr_busy", busy, 0);
    repeat (150) @(negedge clk); #1;
    chk("mr_no_ack0", ack0_cnt, 0);
    tx1 = 16'h1234;
    req1 = 1'b1;
    wait_ack("mr_ack_seen", 400);
    req1 = 1'b0;
    chk("mr_ack1", got1, 1);
    chk("mr_rx_after", rx, 16'h1234);
    chk("mr_ack0_total", ack0_cnt, 0);

    // CLK_DIV=1 instance loopback
    txb0 = 16'h8001;
    reqb0 = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (ackb0) break;
    end
    chk("cd1_ack0", ackb0, 1);
    chk("cd1_ack1", ackb1, 0);
    reqb0 = 1'b0;
    chk("cd1_rx", rxb, 16'h8001);
    chk("cd1_low_cycles", lowb, 33);
    chk("cd1_rises", risesb, 16);
    chk("cd1_period", perb, 2);
    chk("cd1_ss_n", lastlowb, 2'b10);
    repeat (4) @(negedge clk); #1;
    chk("cd1_busy_idle", busyb, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
